cipher_char_sequencer: RTL
==========================

# cipher_char_sequencer

Front-end stage that feeds the 7-bit combinational encrypter one ASCII character at a time.
- Accepts characters on a valid/ready stream and advances a per-character rolling key (7-bit LFSR seeded by software).
- Drives the encrypter's message/key inputs and captures its result.
- Buffers encrypted characters in a small FIFO with message framing (`out_last`, length) for the downstream link.

## Interface
**Parameters**
- `DEPTH`, default 2: output FIFO entries; power of two, 2..8.
- `CNT_W`, default 8: width of per-message character counter.

**Ports** (clock and reset first)
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `key_load`  in  1  one-cycle strobe: load `key_seed` as message key.
- `key_seed`  in  7  seed value; 7'h00 is replaced by 7'h01.
- `key_err`  out  1  one-cycle pulse: `key_load` rejected (mid-message).
- `in_valid`  in  1  upstream character valid.
- `in_ready`  out  1  block can accept a character this cycle.
- `in_char`  in  7  7-bit ASCII; 7'h00 terminates the message.
- `enc_message`  out  7  to encrypter message input (combinational = `in_char`).
- `enc_key`  out  7  to encrypter key input (= current rolling key).
- `enc_result`  in  7  encrypter output; combinational in same cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head.
- `out_data`  out  7  encrypted character at FIFO head.
- `out_last`  out  1  head is the message terminator.
- `out_len`  out  CNT_W  characters before terminator; meaningful when `out_last`=1.

## Operation
- **FSM states:** NOKEY, RUN.
  - NOKEY: `in_ready`=0; `key_load` → RUN with `cur_key`=`seed_key`=seed (0→1), `char_cnt`=0.
  - RUN: `in_ready` = FIFO not full.
- **Accept:** `in_valid` & `in_ready` pushes `{enc_result, last, len}` into the FIFO.
  - Non-zero char: `cur_key` ← LFSR(`cur_key`) = {`cur_key[5:0]`, `cur_key[6]` ^ `cur_key[5]`}; `char_cnt` ← `char_cnt`+1, saturating at all-ones.
  - Zero char: pushed entry has `last`=1, `len`=`char_cnt`, and data forced to 7'h00 regardless of `enc_result`. Then `cur_key` ← `seed_key`, `char_cnt` ← 0. State stays RUN.
- **Key reload:** `key_load` in RUN with `char_cnt`=0 reloads seed and key, no error. With `char_cnt`≠0 it is ignored and `key_err` pulses next cycle.
- **Key load and accept in the same cycle:** when the load is accepted, the character uses the old key and the new seed wins for the next character. When the load is rejected, the character is processed normally.
- **FIFO:** circular, pointer wrap at `DEPTH`, no overflow is possible.
  - Push and pop in the same cycle are allowed when not empty.
  - Pop when `out_valid` & `out_ready`.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_len`=0, `key_err`=0; state NOKEY; FIFO empty; keys 7'h01.
- **Latency:** character accepted at edge N appears at `out_valid` after edge N (one cycle).
- **Input handshake:** `in_ready` does not depend on `in_valid`. It depends on `out_ready` only via registered FIFO count, so there is no combinational in→out path except `enc_message` = `in_char`.
- **Output handshake:** `out_data`, `out_last` and `out_len` hold stable while `out_valid`=1 and `out_ready`=0.
- **Throughput:** one character/cycle sustained when `out_ready`=1.
- **Full FIFO:** `in_ready` drops the cycle after the count reaches `DEPTH`. A pop that cycle re-raises it the following cycle.
- **Reset mid-message:** all state discarded, FIFO emptied, return to NOKEY; no partial frame emitted.

## Structure
- Shared package `cipher_pkg`:
  - `CHAR_W`=7, `KEY_NULL_SUB`=7'h01.
  - State enum {NOKEY, RUN}.
  - FIFO entry struct {data, last, len}.
  - LFSR step function (reused by the downstream decrypt sequencer).
- One sub-module: `cipher_out_fifo` (parameterised DEPTH, entry width), instantiated once.
- Encrypter stays external and is wired by the parent.

## Test plan
- **Reset/no key:** after reset with `in_valid`=1 → `in_ready`=0, `out_valid`=0 indefinitely.
- **Key chain:** seed 7'h01 then chars 'A','B','C',0 → `enc_key` sequence 7'h01, 7'h02, 7'h04, 7'h08. Output is four entries; last has data 7'h00, `out_last`=1, `out_len`=3. Next message starts at key 7'h01.
- **Zero seed:** seed 7'h00 → `enc_key`=7'h01 on first char.
- **Backpressure:** DEPTH=2, `out_ready`=0, stream 5 chars → exactly 2 accepted and `in_ready`=0. Release `out_ready` → remaining chars flow in order, no loss or duplication.
- **Rejected reload:** `key_load` after 2 chars of a message → `key_err` one-cycle pulse, key chain continues unchanged. `key_load` right after terminator → accepted, no `key_err`.
- **Reset mid-stream:** `rst_n`=0 with 2 FIFO entries pending → `out_valid`=0 next cycle, state NOKEY. A fresh key plus a new message then behaves as from cold reset.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the character cipher sequencers (encrypt front-end
// and the downstream decrypt sequencer).
package cipher_pkg;

  localparam int         CHAR_W       = 7;
  localparam logic [6:0] KEY_NULL_SUB = 7'h01;
  localparam int         MAX_CNT_W    = 16;

  typedef enum logic [0:0] {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } seq_state_e;

  // len is sized for the widest supported counter; users zero-extend into it.
  typedef struct packed {
    logic [CHAR_W-1:0]    data;
    logic                 last;
    logic [MAX_CNT_W-1:0] len;
  } fifo_entry_t;

  function automatic logic [CHAR_W-1:0] lfsr_step(input logic [CHAR_W-1:0] key);
    return {key[5:0], key[6] ^ key[5]};
  endfunction

endpackage

// File: rtl/cipher_out_fifo.sv
// Small circular FIFO holding encrypted characters with framing.
// The head word is read straight from storage, so it holds steady until popped.
module cipher_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] head_data,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state: DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/cipher_char_sequencer.sv
// Feeds an external combinational encrypter one character at a time with a
// rolling LFSR key and queues the results with message framing.
module cipher_char_sequencer
  import cipher_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [CHAR_W-1:0] key_seed,
  output logic              key_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  output logic [CHAR_W-1:0] enc_message,
  output logic [CHAR_W-1:0] enc_key,
  input  logic [CHAR_W-1:0] enc_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e        state_q, state_d;
  logic [CHAR_W-1:0] cur_key_q, cur_key_d;
  logic [CHAR_W-1:0] seed_key_q, seed_key_d;
  logic [CNT_W-1:0]  char_cnt_q, char_cnt_d;
  logic              key_err_q, key_err_d;

  logic              fifo_full_s;
  logic              accept_s;
  logic              is_term_s;
  logic [CHAR_W-1:0] seed_fix_s;
  fifo_entry_t       push_entry_s;
  fifo_entry_t       head_entry_s;

  assign seed_fix_s  = (key_seed == 7'h00) ? KEY_NULL_SUB : key_seed;
  assign in_ready    = (state_q == RUN) && !fifo_full_s;
  assign accept_s    = in_valid && in_ready;
  assign is_term_s   = (in_char == 7'h00);
  assign enc_message = in_char;
  assign enc_key     = cur_key_q;

  // The terminator's data is forced to zero so the link sees a clean frame end.
  always_comb begin
    push_entry_s.data = is_term_s ? 7'h00 : enc_result;
    push_entry_s.last = is_term_s;
    push_entry_s.len  = is_term_s ? MAX_CNT_W'(char_cnt_q) : '0;
  end

  // Key chain and message counter; a load only wins between messages.
  always_comb begin
    state_d    = state_q;
    cur_key_d  = cur_key_q;
    seed_key_d = seed_key_q;
    char_cnt_d = char_cnt_q;
    key_err_d  = 1'b0;
    case (state_q)
      NOKEY: begin
        if (key_load) begin
          state_d    = RUN;
          cur_key_d  = seed_fix_s;
          seed_key_d = seed_fix_s;
          char_cnt_d = '0;
        end else begin
          state_d = NOKEY;
        end
      end
      RUN: begin
        if (accept_s && is_term_s) begin
          cur_key_d  = seed_key_q;
          char_cnt_d = '0;
        end else if (accept_s) begin
          cur_key_d  = lfsr_step(cur_key_q);
          char_cnt_d = (char_cnt_q == CNT_MAX) ? char_cnt_q : char_cnt_q + CNT_W'(1);
        end else begin
          cur_key_d = cur_key_q;
        end
        if (key_load && (char_cnt_q == '0)) begin
          seed_key_d = seed_fix_s;
          cur_key_d  = seed_fix_s;
        end else if (key_load) begin
          key_err_d = 1'b1;
        end else begin
          key_err_d = 1'b0;
        end
      end
      default: state_d = NOKEY;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= NOKEY;
      cur_key_q  <= KEY_NULL_SUB;
      seed_key_q <= KEY_NULL_SUB;
      char_cnt_q <= '0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_key_q  <= cur_key_d;
      seed_key_q <= seed_key_d;
      char_cnt_q <= char_cnt_d;
      key_err_q  <= key_err_d;
    end
  end

  cipher_out_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept_s),
    .push_data (push_entry_s),
    .pop       (out_valid && out_ready),
    .out_valid (out_valid),
    .head_data (head_entry_s),
    .full      (fifo_full_s)
  );

  assign key_err  = key_err_q;
  assign out_data = head_entry_s.data;
  assign out_last = head_entry_s.last;
  assign out_len  = CNT_W'(head_entry_s.len);

endmodule
